// File: rtl/tx_packet_distributor.sv
// Steers whole AXI-Stream frames to one of M_COUNT transmit ports by first-beat tdest,
// dropping (and counting) frames for absent or disabled ports.
module tx_packet_distributor #(
  parameter int M_COUNT         = 3,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 2,
  parameter int AXIS_USER_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [AXIS_DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]           s_axis_tkeep,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  input  logic [AXIS_DEST_WIDTH-1:0]           s_axis_tdest,
  input  logic [AXIS_USER_WIDTH-1:0]           s_axis_tuser,
  output logic [M_COUNT*AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [M_COUNT*AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic [M_COUNT-1:0]                   m_axis_tvalid,
  input  logic [M_COUNT-1:0]                   m_axis_tready,
  output logic [M_COUNT-1:0]                   m_axis_tlast,
  output logic [M_COUNT*AXIS_USER_WIDTH-1:0]   m_axis_tuser,
  input  logic [M_COUNT-1:0]                   w_port_enable,
  input  logic                                 w_rst_drop_counter,
  output logic [31:0]                          w_drop_counter
);

  typedef enum logic [1:0] {IDLE, FORWARD, DROP} state_t;

  state_t                     state, state_next;
  logic [AXIS_DEST_WIDTH-1:0] sel, sel_next;
  logic [AXIS_DEST_WIDTH-1:0] cur_port;
  logic                       route_valid;
  logic                       port_free;
  logic                       steer;
  logic                       drop_first;
  logic [M_COUNT-1:0]         load;

  // Compare against each legal index so an out-of-range tdest never indexes the enable vector.
  always_comb begin
    route_valid = 1'b0;
    for (int i = 0; i < M_COUNT; i++)
      if (s_axis_tdest == AXIS_DEST_WIDTH'(i) && w_port_enable[i]) route_valid = 1'b1;
  end

  assign cur_port = (state == FORWARD) ? sel : s_axis_tdest;

  always_comb begin
    port_free = 1'b0;
    for (int i = 0; i < M_COUNT; i++)
      if (cur_port == AXIS_DEST_WIDTH'(i)) port_free = !m_axis_tvalid[i] || m_axis_tready[i];
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_next    = state;
    sel_next      = sel;
    s_axis_tready = 1'b0;
    steer         = 1'b0;
    drop_first    = 1'b0;
    case (state)
      IDLE: begin
        if (route_valid) begin
          s_axis_tready = port_free;
          steer         = 1'b1;
          if (s_axis_tvalid && port_free && !s_axis_tlast) begin
            state_next = FORWARD;
            sel_next   = s_axis_tdest;
          end
        end else begin
          s_axis_tready = 1'b1;
          if (s_axis_tvalid) begin
            drop_first = 1'b1;
            if (!s_axis_tlast) state_next = DROP;
          end
        end
      end
      FORWARD: begin
        s_axis_tready = port_free;
        steer         = 1'b1;
        if (s_axis_tvalid && port_free && s_axis_tlast) state_next = IDLE;
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < M_COUNT; i++)
      load[i] = steer && s_axis_tvalid && port_free && (cur_port == AXIS_DEST_WIDTH'(i));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
    end else begin
      state <= state_next;
      sel   <= sel_next;
    end
  end

  // NOTE: the payload registers are reset too, so idle ports present all-zero buses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      for (int i = 0; i < M_COUNT; i++) begin
        if (load[i]) begin
          m_axis_tvalid[i]                                   <= 1'b1;
          m_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH] <= s_axis_tdata;
          m_axis_tkeep[i*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH] <= s_axis_tkeep;
          m_axis_tlast[i]                                    <= s_axis_tlast;
          m_axis_tuser[i*AXIS_USER_WIDTH +: AXIS_USER_WIDTH] <= s_axis_tuser;
        end else if (m_axis_tready[i]) begin
          m_axis_tvalid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         w_drop_counter <= '0;
    else if (w_rst_drop_counter)                        w_drop_counter <= '0;
    else if (drop_first && w_drop_counter != 32'hFFFF_FFFF) w_drop_counter <= w_drop_counter + 32'd1;
  end

endmodule

// File: doc/tx_packet_distributor.md
# tx_packet_distributor

Egress-side counterpart of the RX scheduling path. It takes the single merged AXI-Stream frame stream produced after priority scheduling and steers each whole frame to one of `M_COUNT` transmit ports, selected by the frame's first-beat `tdest`. Frames addressed to a nonexistent or disabled port are consumed and dropped, and each drop is counted. Each output port has a one-stage register, so routing is frame-atomic at full line rate.

## Interface
Parameters:
- `M_COUNT`, 3: number of transmit ports.
- `AXIS_DATA_WIDTH`, 64: tdata width.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`: tkeep width.
- `AXIS_DEST_WIDTH`, 2: tdest width; must be ≥ `$clog2(M_COUNT)`.
- `AXIS_USER_WIDTH`, 16: tuser width (packet length), passed through unchanged.

Ports (the `m_axis_*` buses are packed, with port i at slice i):
- `clk`  in  1  the single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  `AXIS_DATA_WIDTH`  input stream data.
- `s_axis_tkeep`  in  `AXIS_KEEP_WIDTH`  input stream byte enables.
- `s_axis_tvalid`  in  1  input stream valid.
- `s_axis_tready`  out  1  input stream ready.
- `s_axis_tlast`  in  1  input stream end of frame.
- `s_axis_tdest`  in  `AXIS_DEST_WIDTH`  destination port; sampled on the first beat only.
- `s_axis_tuser`  in  `AXIS_USER_WIDTH`  frame length.
- `m_axis_tdata`  out  `M_COUNT*AXIS_DATA_WIDTH`  per-port data.
- `m_axis_tkeep`  out  `M_COUNT*AXIS_KEEP_WIDTH`  per-port byte enables.
- `m_axis_tvalid`  out  `M_COUNT`  per-port valid.
- `m_axis_tready`  in  `M_COUNT`  per-port ready.
- `m_axis_tlast`  out  `M_COUNT`  per-port end of frame.
- `m_axis_tuser`  out  `M_COUNT*AXIS_USER_WIDTH`  per-port frame length.
- `w_port_enable`  in  `M_COUNT`  per-port enable; sampled on the first beat only.
- `w_rst_drop_counter`  in  1  synchronous clear of the drop counter.
- `w_drop_counter`  out  32  count of dropped frames, saturating.

## Operation
State machine states:
- IDLE: at a frame boundary. The route is decided combinationally from the current beat's `tdest` and `w_port_enable`.
- FORWARD: mid-frame. The selected port index `sel` is latched.
- DROP: mid-frame. Beats are discarded.

Route decision in IDLE:
- The route is valid when `tdest < M_COUNT` and `w_port_enable[tdest]` is 1.

IDLE with a valid route:
- `s_axis_tready` = `!m_axis_tvalid[tdest] || m_axis_tready[tdest]`.
- On handshake, the beat is loaded into the output register of port `tdest`.
- If `tlast` is 0, go to FORWARD with `sel` = `tdest`. If `tlast` is 1, stay in IDLE.

IDLE with an invalid route:
- `s_axis_tready` = 1.
- On handshake, the beat is discarded and the drop counter increments.
- If `tlast` is 0, go to DROP.

FORWARD:
- `s_axis_tready` = `!m_axis_tvalid[sel] || m_axis_tready[sel]`.
- Beats load into the register of port `sel`.
- The beat with `tlast` set returns the machine to IDLE.
- `tdest` and `w_port_enable` changes mid-frame are ignored. Disabling a port mid-frame never truncates the frame.

DROP:
- `s_axis_tready` = 1; beats are discarded.
- The beat with `tlast` set returns the machine to IDLE.

Output registers (per port):
- `m_axis_tvalid[i]` sets on load.
- It clears on `m_axis_tready[i]` when no new load happens in the same cycle.
- A simultaneous drain and load keeps `tvalid` at 1 with the new beat.
- Ports other than the selected one are never disturbed.

Drop counter:
- 32-bit; +1 per dropped frame, counted on the first-beat handshake only.
- Saturates at 0xFFFFFFFF.
- `w_rst_drop_counter` clears it to 0 and takes priority over a same-cycle increment.

Reset (`rst_n` low, asynchronous):
- State goes to IDLE, `sel` to 0, and the drop counter to 0.
- All `m_axis_tvalid` go to 0.
- All `m_axis_tdata`, `tkeep`, `tlast` and `tuser` registers go to 0.
- A frame interrupted by reset is lost. The next beat after release is treated as a first beat.

## Timing
- Latency: an input beat accepted at edge N is presented on `m_axis_*` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while the selected port's `tready` stays high, including back-to-back frames to the same or different ports.
- `s_axis_tready` is a combinational function of state, `tdest`, the enables, and the selected port's `tvalid`/`tready`. No combinational path exists from `s_axis_tvalid` to `s_axis_tready`.
- Back-to-back frames to different ports: the new frame's first beat is accepted in the cycle after the previous `tlast` when the new port's register is free. The old port may still be draining.
- All `m_axis_*` signals are held stable while `m_axis_tvalid[i]` is 1 and `m_axis_tready[i]` is 0.
- `w_drop_counter` updates 1 cycle after the dropped first beat's handshake.

## Test plan
- Routing: 3-beat frame, `tdest`=1, `tuser`=24, all ports enabled, all readies high → 3 beats appear on port 1 one cycle after each accept, with `tuser`=24 and `tlast` on beat 3. Ports 0 and 2 keep `tvalid`=0 throughout.
- Invalid destination: 2-beat frame with `tdest`=3 (`M_COUNT`=3), then a frame with `tdest`=0 and `w_port_enable`=3'b110 → all 3 beats accepted back-to-back with no output on any port, and `w_drop_counter` goes 0→1→2.
- Backpressure: 4-beat frame to port 0, with `m_axis_tready[0]` low for 4 cycles after beat 2 → `s_axis_tready` low for those 4 cycles. Output sequence is beats 1–4 exactly, with no duplication or loss and data stable while stalled.
- Frame atomicity: `tdest` switched 2→0 and `w_port_enable[2]` cleared on beat 2 of a 3-beat frame to port 2 → all 3 beats still exit port 2, and port 0 stays idle.
- Counter edges: counter preloaded to 0xFFFFFFFF by 2^32-1 drops (or forced), then one more drop → stays 0xFFFFFFFF. `w_rst_drop_counter` asserted in the same cycle as a drop → counter reads 0.
- Reset mid-frame: `rst_n` pulsed low during beat 2 of a 4-beat frame → all `m_axis_tvalid` drop to 0 immediately and the counter reads 0. A subsequent 1-beat frame with `tdest`=2 routes correctly to port 2.
